// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter: core writeback vs. queued accelerator results
// Optional starvation guard compiled in with `define WB_STARVE_GUARD_EN.
module wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_wr_en,
   input  logic [4:0]  core_rd,
   input  logic [31:0] core_data,
   input  logic        acc_valid,
   output logic        acc_ready,
   input  logic [4:0]  acc_rd,
   input  logic [31:0] acc_data,
   output logic        write_reg,
   output logic [4:0]  rd,
   output logic [31:0] data_in,
   output logic [31:0] busy_mask,
   output logic        stall_core
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("wb_arbiter: DEPTH must be a power of 2 and at least 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("wb_arbiter: STARVE_LIMIT must be at least 1");
   end

   logic [4:0]  rd_mem   [DEPTH];
   logic [31:0] data_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic core_sel;

   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign acc_ready = !reset && !full;

   // x0 results complete the handshake but are never stored.
   assign push      = acc_valid && acc_ready && (acc_rd != 5'd0);
   assign core_sel  = !reset && core_wr_en && (core_rd != 5'd0) && !stall_core;
   assign pop       = !reset && !core_sel && !empty;

   always_comb begin
      write_reg = 1'b0;
      rd        = 5'd0;
      data_in   = 32'd0;
      if (core_sel) begin
         write_reg = 1'b1;
         rd        = core_rd;
         data_in   = core_data;
      end else if (pop) begin
         write_reg = 1'b1;
         rd        = rd_mem[rd_ptr];
         data_in   = data_mem[rd_ptr];
      end
   end

   // Entries are walked from the head; only the first count slots are live.
   always_comb begin
      busy_mask = 32'd0;
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count) begin
               busy_mask[rd_mem[rd_ptr + AW'(i)]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= acc_rd;
         data_mem[wr_ptr] <= acc_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;

   assign stall_core = !reset && !empty && (starve_cnt == SW'(STARVE_LIMIT));

   // Counts cycles the queue head loses the port to the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (pop || empty) begin
         starve_cnt <= '0;
      end else if (core_sel) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`else
   assign stall_core = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;
`ifdef WB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_wr_en = 1'b0;
   logic [4:0]  core_rd = 5'd0;
   logic [31:0] core_data = 32'd0;
   logic        acc_valid = 1'b0;
   logic        acc_ready;
   logic [4:0]  acc_rd = 5'd0;
   logic [31:0] acc_data = 32'd0;
   logic        write_reg;
   logic [4:0]  rd;
   logic [31:0] data_in;
   logic [31:0] busy_mask;
   logic        stall_core;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .core_wr_en(core_wr_en), .core_rd(core_rd), .core_data(core_data),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_rd(acc_rd), .acc_data(acc_data),
      .write_reg(write_reg), .rd(rd), .data_in(data_in),
      .busy_mask(busy_mask), .stall_core(stall_core)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic        w;
      logic        ready;
      logic [31:0] busy;
      logic        stall;
   } status_t;

   wr_t     model_q [$];
   wr_t     wr_q    [$];
   status_t st_q    [$];
   int      starve = 0;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of inputs, predict the DUT's response, advance the model.
   task automatic step(input bit rst, input bit cwe, input logic [4:0] crd, input logic [31:0] cdat,
                       input bit av, input logic [4:0] ard, input logic [31:0] adat);
      status_t s;
      wr_t     w;
      bit      fifo_w;
      int      sz;
      @(posedge clk);
      #1;
      reset = rst; core_wr_en = cwe; core_rd = crd; core_data = cdat;
      acc_valid = av; acc_rd = ard; acc_data = adat;
      s = '0;
      fifo_w = 1'b0;
      sz = model_q.size();
      if (rst) begin
         model_q.delete();
         starve = 0;
      end else begin
         s.ready = (sz < DEPTH);
         s.stall = GUARD && (sz > 0) && (starve == STARVE_LIMIT);
         foreach (model_q[i]) s.busy[model_q[i].rd] = 1'b1;
         if (cwe && crd != 5'd0 && !s.stall) begin
            s.w = 1'b1;
            w = '{rd: crd, data: cdat};
         end else if (sz > 0) begin
            s.w = 1'b1;
            fifo_w = 1'b1;
            w = model_q[0];
         end
         if (s.w) wr_q.push_back(w);
         if (fifo_w) void'(model_q.pop_front());
         if (av && s.ready && ard != 5'd0) model_q.push_back('{rd: ard, data: adat});
         if (GUARD) starve = (sz == 0 || fifo_w) ? 0 : starve + 1;
      end
      st_q.push_back(s);
   endtask

   always @(negedge clk) begin
      status_t s;
      wr_t     w;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         chk("write_reg", 64'(write_reg), 64'(s.w));
         chk("acc_ready", 64'(acc_ready), 64'(s.ready));
         chk("busy_mask", 64'(busy_mask), 64'(s.busy));
         chk("stall_core", 64'(stall_core), 64'(s.stall));
         if (write_reg) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 64'({rd, data_in}), 64'h0);
            end else begin
               w = wr_q.pop_front();
               chk("write_port", 64'({rd, data_in}), 64'(w));
            end
         end else begin
            chk("idle_port_zero", 64'({rd, data_in}), 64'h0);
         end
      end
   end

   initial begin
      // Reset
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);

      // Single accelerator result with idle core
      step(0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);

      // Core writes every cycle while results pile up, then stays blocked
      for (int i = 0; i < 4; i++) step(0, 1, 5'd3, 32'h100 + i, 1, 5'(10 + i), 32'hA0 + i);
      for (int i = 0; i < 12; i++) step(0, 1, 5'd3, 32'h200 + i, 1, 5'd20, 32'hBB);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // Core x0 write yields to queue head; x0 accelerator result is dropped
      step(0, 1, 5'd3, 32'h1, 1, 5'd7, 32'h77);
      step(0, 1, 5'd0, 32'h2, 1, 5'd0, 32'hFF);
      step(0, 1, 5'd0, 32'h3, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);

      // Fill to full, then drain with idle core and acc_valid held
      for (int i = 1; i <= 4; i++) step(0, 1, 5'd2, 32'h300 + i, 1, 5'(i), 32'h400 + i);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 5'd9, 32'h900 + i);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // Reset with three entries queued
      for (int i = 1; i <= 3; i++) step(0, 1, 5'd4, 32'h500 + i, 1, 5'(i + 16), 32'h600 + i);
      repeat (2) step(1, 0, 0, 0, 1, 5'd8, 32'h1);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit rst_r;
         bit cwe_r;
         bit av_r;
         logic [4:0] crd_r;
         logic [4:0] ard_r;
         rst_r = ($urandom_range(0, 199) == 0);
         cwe_r = ($urandom_range(0, 99) < 60);
         av_r  = ($urandom_range(0, 99) < 50);
         crd_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ard_r = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(rst_r, cwe_r, crd_r, 32'($urandom), av_r, ard_r, 32'($urandom));
      end
      repeat (8) step(0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("status_queue_drained", 64'(st_q.size()), 64'h0);
      chk("write_queue_drained", 64'(wr_q.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning accelerator result FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive FIFO-blocked cycles before forced drain.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port core_wr_en  input  1  core pipeline writeback request.
REQ-006 SHALL have port core_rd  input  5  core destination register.
REQ-007 SHALL have port core_data  input  32  core writeback value.
REQ-008 SHALL have port acc_valid  input  1  GEMM accelerator result valid.
REQ-009 SHALL have port acc_ready  output  1  FIFO can accept; equals !full, no combinational path from acc_valid.
REQ-010 SHALL have port acc_rd  input  5  accelerator destination register.
REQ-011 SHALL have port acc_data  input  32  accelerator result value.
REQ-012 SHALL have port write_reg  output  1  register-file write enable.
REQ-013 SHALL have port rd  output  5  register-file write address.
REQ-014 SHALL have port data_in  output  32  register-file write data.
REQ-015 SHALL have port busy_mask  output  32  bit n set while any valid FIFO entry targets xn.
REQ-016 SHALL have port stall_core  output  1  core must hold its writeback this cycle.

Function
REQ-017 SHALL enqueue {acc_rd, acc_data} when acc_valid && acc_ready, except acc_rd==0: handshake completes, entry discarded.
REQ-018 SHALL drive write port combinationally: core write if core_wr_en && core_rd!=0 && !stall_core; else FIFO head if non-empty; else write_reg=0.
REQ-019 SHALL treat core write to x0 as no request, giving the slot to the FIFO head.
REQ-020 SHALL dequeue the FIFO head in exactly the cycle it drives the write port; minimum accelerator-to-write latency 1 cycle.
REQ-021 SHALL allow simultaneous enqueue and dequeue, count unchanged; when full, acc_ready=0 even if dequeuing that cycle.
REQ-022 SHALL wrap read/write pointers modulo DEPTH, full/empty from an occupancy counter 0..DEPTH.
REQ-023 SHALL preserve FIFO order; same-rd entries write in arrival order.
REQ-024 SHALL compute busy_mask combinationally from valid entries; entry dequeued this cycle still shows until the following cycle.
REQ-025 SHALL keep write_reg, rd, data_in at 0 when no write selected.

Reset
REQ-026 SHALL on reset empty FIFO, zero pointers, occupancy and starve counter; acc_ready=0, write_reg=0, busy_mask=0, stall_core=0 while reset high.
REQ-027 SHALL discard FIFO contents and any in-flight handshake when reset asserts mid-operation; acc_ready=1 first cycle after reset release.

Configuration
REQ-028 SHALL compile starvation guard only when macro WB_STARVE_GUARD_EN is defined.
REQ-029 With WB_STARVE_GUARD_EN: counter increments each cycle FIFO non-empty and core write wins; clears on dequeue or empty; when counter==STARVE_LIMIT, stall_core=1, FIFO head wins, counter clears.
REQ-030 Without WB_STARVE_GUARD_EN: stall_core tied 0, no counter logic; FIFO drains only in core-idle cycles.

Verification
REQ-031 Idle core, acc_valid 1 cycle, rd=5, data=0xDEAD_BEEF -> next cycle write_reg=1, rd=5, data_in=0xDEADBEEF, busy_mask bit5 set that cycle only.
REQ-032 Core writes rd=3 every cycle, 4 acc results pushed -> acc_ready=0 after 4th; with guard, stall_core=1 on 9th blocked cycle and FIFO head written.
REQ-033 Same cycle core rd=0 write and FIFO head rd=7 -> rd=7 written; acc_rd=0 push -> accepted, never written, busy_mask unchanged.
REQ-034 Full FIFO, idle core, acc_valid held -> one dequeue per cycle, acc_ready returns 1 cycle after first dequeue, order rd 1,2,3,4 preserved.
REQ-035 Reset asserted with 3 entries queued -> no writes after reset, busy_mask=0, acc_ready=1 first post-reset cycle.
